// File: rtl/vga_scan_ctrl_if.sv
// Scan/video bus between vga_scan_ctrl (master) and the SoC pixel source / board pins (slave).
// Frame interrupt signals exist only when VGA_FRAME_IRQ_EN is defined.
interface vga_scan_ctrl_if;
   logic [9:0]  pixel_x;
   logic [8:0]  pixel_y;
   logic        pixel;
   logic        video_on;
   logic        frame_start;
   logic        vga_hsync;
   logic        vga_vsync;
   logic [11:0] vga_rgb;
`ifdef VGA_FRAME_IRQ_EN
   logic        frame_irq;
   logic        irq_clear;

   modport master (
      output pixel_x, pixel_y, video_on, frame_start, vga_hsync, vga_vsync, vga_rgb, frame_irq,
      input  pixel, irq_clear
   );
   modport slave (
      input  pixel_x, pixel_y, video_on, frame_start, vga_hsync, vga_vsync, vga_rgb, frame_irq,
      output pixel, irq_clear
   );
`else
   modport master (
      output pixel_x, pixel_y, video_on, frame_start, vga_hsync, vga_vsync, vga_rgb,
      input  pixel
   );
   modport slave (
      input  pixel_x, pixel_y, video_on, frame_start, vga_hsync, vga_vsync, vga_rgb,
      output pixel
   );
`endif
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: pixel divider, h/v counters, registered coordinates and a
// one-pixel-delayed sync/colour stage. Define VGA_FRAME_IRQ_EN for the sticky frame_irq.
module vga_scan_ctrl #(
   parameter int          CLK_DIV   = 2,
   parameter int          H_VISIBLE = 640,
   parameter int          H_FRONT   = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BACK    = 48,
   parameter int          V_VISIBLE = 480,
   parameter int          V_FRONT   = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BACK    = 33,
   parameter logic [11:0] FG_COLOUR = 12'hFFF,
   parameter logic [11:0] BG_COLOUR = 12'h000
) (
   input logic             HCLK,
   input logic             HRESETn,
   vga_scan_ctrl_if.master bus
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [1:0] div;
   logic       pix_en;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       vis_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       hs_d;
   logic       vs_d;

   // Everything registered at a pixel edge is derived from the post-increment counts.
   always_comb begin
      pix_en  = (div == DIV_LAST);
      h_nxt   = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
      v_nxt   = v_cnt;
      if (h_cnt == H_LAST) begin
         v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end
      vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hs_nxt  = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
      vs_nxt  = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         div <= 2'd0;
      end else if (pix_en) begin
         div <= 2'd0;
      end else begin
         div <= div + 2'd1;
      end
   end

   // video_on doubles as the delayed visible flag: it describes the coordinate now on pixel_x/y,
   // whose pixel value is sampled at the following pixel edge.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         h_cnt         <= 10'd0;
         v_cnt         <= 10'd0;
         bus.pixel_x   <= 10'd0;
         bus.pixel_y   <= 9'd0;
         bus.video_on  <= 1'b0;
         hs_d          <= 1'b0;
         vs_d          <= 1'b0;
         bus.vga_rgb   <= 12'h000;
         bus.vga_hsync <= 1'b1;
         bus.vga_vsync <= 1'b1;
      end else if (pix_en) begin
         h_cnt         <= h_nxt;
         v_cnt         <= v_nxt;
         bus.pixel_x   <= vis_nxt ? h_nxt : 10'd0;
         bus.pixel_y   <= vis_nxt ? v_nxt[8:0] : 9'd0;
         bus.video_on  <= vis_nxt;
         hs_d          <= hs_nxt;
         vs_d          <= vs_nxt;
         bus.vga_rgb   <= bus.video_on ? (bus.pixel ? FG_COLOUR : BG_COLOUR) : 12'h000;
         bus.vga_hsync <= ~hs_d;
         bus.vga_vsync <= ~vs_d;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         bus.frame_start <= 1'b0;
      end else begin
         bus.frame_start <= pix_en && (h_nxt == 10'd0) && (v_nxt == 10'd0);
      end
   end

`ifdef VGA_FRAME_IRQ_EN
   // A new frame outranks a simultaneous clear so no frame event is lost.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         bus.frame_irq <= 1'b0;
      end else if (bus.frame_start) begin
         bus.frame_irq <= 1'b1;
      end else if (bus.irq_clear) begin
         bus.frame_irq <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a reduced-timing instance checked every cycle against a positional
// model, plus a default 640x480 instance pinned to literal line timing.
module tb_vga_scan_ctrl;
   localparam int T_DIV = 2;
   localparam int T_HV = 16, T_HF = 2, T_HS = 4, T_HB = 3;
   localparam int T_VV = 6,  T_VF = 1, T_VS = 2, T_VB = 2;
   localparam int T_HT = T_HV + T_HF + T_HS + T_HB;
   localparam int T_VT = T_VV + T_VF + T_VS + T_VB;
   localparam int T_F  = T_HT * T_VT;
   localparam logic [11:0] T_FG = 12'hA5C;
   localparam logic [11:0] T_BG = 12'h123;

   logic HCLK;
   logic HRESETn;

   vga_scan_ctrl_if bus ();
   vga_scan_ctrl_if bus_full ();

   vga_scan_ctrl #(
      .CLK_DIV(T_DIV),
      .H_VISIBLE(T_HV), .H_FRONT(T_HF), .H_SYNC(T_HS), .H_BACK(T_HB),
      .V_VISIBLE(T_VV), .V_FRONT(T_VF), .V_SYNC(T_VS), .V_BACK(T_VB),
      .FG_COLOUR(T_FG), .BG_COLOUR(T_BG)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
   );

   vga_scan_ctrl dut_full (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_full)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit m_vis(input int p);
      return ((p % T_HT) < T_HV) && ((p / T_HT) < T_VV);
   endfunction

   function automatic bit m_hs(input int p);
      return ((p % T_HT) >= T_HV + T_HF) && ((p % T_HT) < T_HV + T_HF + T_HS);
   endfunction

   function automatic bit m_vs(input int p);
      return ((p / T_HT) >= T_VV + T_VF) && ((p / T_HT) < T_VV + T_VF + T_VS);
   endfunction

   // t counts HCLK rising edges since reset release; n counts pixel edges.
   int t = 0;
   int n, p, q;
   bit samp = 1'b0;
   bit pix_drv;
   int e_hs, e_vs, e_rgb;
`ifdef VGA_FRAME_IRQ_EN
   bit exp_irq  = 1'b0;
   bit prev_fs  = 1'b0;
   bit prev_clr = 1'b0;
   bit clr_drv;
   bit coincide = 1'b0;
   int since_fs = 0;
`endif

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         t = 0;
         check("rst_pixel_x",     32'(bus.pixel_x), 0);
         check("rst_pixel_y",     32'(bus.pixel_y), 0);
         check("rst_video_on",    32'(bus.video_on), 0);
         check("rst_frame_start", 32'(bus.frame_start), 0);
         check("rst_hsync",       32'(bus.vga_hsync), 1);
         check("rst_vsync",       32'(bus.vga_vsync), 1);
         check("rst_rgb",         32'(bus.vga_rgb), 0);
`ifdef VGA_FRAME_IRQ_EN
         exp_irq = 1'b0;
         prev_fs = 1'b0;
         check("rst_frame_irq", 32'(bus.frame_irq), 0);
`endif
      end else begin
         t++;
         n = t / T_DIV;
         p = n % T_F;
         check("pixel_x",     32'(bus.pixel_x),  m_vis(p) ? p % T_HT : 0);
         check("pixel_y",     32'(bus.pixel_y),  m_vis(p) ? p / T_HT : 0);
         check("video_on",    32'(bus.video_on), (n > 0 && m_vis(p)) ? 1 : 0);
         check("frame_start", 32'(bus.frame_start),
               ((t % T_DIV) == 0 && n > 0 && p == 0) ? 1 : 0);
         if (n >= 2) begin
            q     = (n - 1) % T_F;
            e_hs  = m_hs(q) ? 0 : 1;
            e_vs  = m_vs(q) ? 0 : 1;
            e_rgb = m_vis(q) ? (samp ? int'(T_FG) : int'(T_BG)) : 0;
         end else begin
            e_hs  = 1;
            e_vs  = 1;
            e_rgb = 0;
         end
         check("vga_hsync", 32'(bus.vga_hsync), e_hs);
         check("vga_vsync", 32'(bus.vga_vsync), e_vs);
         check("vga_rgb",   32'(bus.vga_rgb),   e_rgb);
`ifdef VGA_FRAME_IRQ_EN
         if (prev_fs) exp_irq = 1'b1;
         else if (prev_clr) exp_irq = 1'b0;
         check("frame_irq", 32'(bus.frame_irq), 32'(exp_irq));
         prev_fs = ((t % T_DIV) == 0 && n > 0 && p == 0);
`endif
      end
      pix_drv   = 1'($urandom_range(0, 1));
      bus.pixel = pix_drv;
      if (((t + 1) % T_DIV) == 0) samp = pix_drv;
`ifdef VGA_FRAME_IRQ_EN
      // Hold off clears for a while after each frame so the flag is seen to stick,
      // and on alternate frames clear in the very cycle frame_start is high.
      if (prev_fs) begin
         since_fs = 0;
         coincide = ~coincide;
         clr_drv  = coincide;
      end else begin
         since_fs++;
         clr_drv = (since_fs > 12) && ($urandom_range(0, 7) == 0);
      end
      bus.irq_clear = clr_drv;
      prev_clr      = clr_drv;
`endif
   end

   int px1, px2;
   int f_fall1, f_rise1, f_fall2, s_fall, s_fs;
   bit f_prev, s_prev;

   initial begin
      HRESETn        = 1'b1;
      bus.pixel      = 1'b0;
      bus_full.pixel = 1'b0;
`ifdef VGA_FRAME_IRQ_EN
      bus.irq_clear      = 1'b0;
      bus_full.irq_clear = 1'b0;
`endif
      #1 HRESETn = 1'b0;
      repeat (10) @(negedge HCLK);
      #2 HRESETn = 1'b1;

      px1 = -1; px2 = -1;
      f_fall1 = -1; f_rise1 = -1; f_fall2 = -1; s_fall = -1; s_fs = -1;
      f_prev = 1'b1; s_prev = 1'b1;
      for (int c = 1; c <= 3000; c++) begin
         @(posedge HCLK);
         #1;
         if (c == 1) px1 = int'(bus_full.pixel_x);
         if (c == 2) px2 = int'(bus_full.pixel_x);
         if (f_prev && !bus_full.vga_hsync) begin
            if (f_fall1 < 0) f_fall1 = c;
            else if (f_fall2 < 0) f_fall2 = c;
         end
         if (!f_prev && bus_full.vga_hsync && f_rise1 < 0) f_rise1 = c;
         if (s_prev && !bus.vga_hsync && s_fall < 0) s_fall = c;
         if (bus.frame_start && s_fs < 0) s_fs = c;
         f_prev = bus_full.vga_hsync;
         s_prev = bus.vga_hsync;
      end
      check("full_pixel_x_c1", px1, 0);
      check("full_pixel_x_c2", px2, 1);
      check("full_hsync_fall", f_fall1, 1314);
      check("full_hsync_low",  f_rise1 - f_fall1, 192);
      check("full_h_period",   f_fall2 - f_fall1, 1600);
      check("small_hsync_fall", s_fall, 2 * (T_HV + T_HF + 1));
      check("small_first_frame_start", s_fs, 550);

      // Reset in the middle of a line, away from any clock edge.
      repeat ($urandom_range(50, 400)) @(posedge HCLK);
      #3 HRESETn = 1'b0;
      repeat (5) @(negedge HCLK);
      #2 HRESETn = 1'b1;

      s_fs = -1;
      for (int c = 1; c <= 700; c++) begin
         @(posedge HCLK);
         #1;
         if (bus.frame_start && s_fs < 0) s_fs = c;
      end
      check("frame_start_after_midreset", s_fs, 550);

      repeat (1200) @(posedge HCLK);
      @(negedge HCLK);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
